// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types, default widths and lane helpers for the memory stage.
// Contents: size_e (access size), state_e (FSM state), XLEN_D/REG_W_D defaults,
// size_mask (low address bits that must be zero for an aligned access),
// gen_strb (byte strobes for a doubleword lane).
package mem_stage_pkg;
    localparam int XLEN_D  = 64;
    localparam int REG_W_D = 6;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    function automatic logic [2:0] size_mask(size_e sz);
        return sz == SZ_B ? 3'd0 : sz == SZ_H ? 3'd1 : sz == SZ_W ? 3'd3 : 3'd7;
    endfunction

    function automatic logic [7:0] gen_strb(size_e sz, logic [2:0] off);
        logic [7:0] base;
        base = sz == SZ_B ? 8'h01 : sz == SZ_H ? 8'h03 : sz == SZ_W ? 8'h0F : 8'hFF;
        return base << off;
    endfunction
endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: selects the addressed lane of a load doubleword and extends it to XLEN.
// Ports: rdata_i (full doubleword), offset_i (byte offset), size_i (access size),
// unsigned_i (zero-extend when 1), result_o (extended load value).
module load_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_D
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      offset_i,
    input  size_e           size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] result_o
);
    logic [XLEN-1:0] lane;

    assign lane = rdata_i >> {offset_i, 3'b000};

    assign result_o = size_i == SZ_B ? {{(XLEN-8){~unsigned_i & lane[7]}}, lane[7:0]}
                    : size_i == SZ_H ? {{(XLEN-16){~unsigned_i & lane[15]}}, lane[15:0]}
                    : size_i == SZ_W ? {{(XLEN-32){~unsigned_i & lane[31]}}, lane[31:0]}
                    : lane;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; passes ALU results through and runs one bus load/store at a time.
// Ports: clk/reset (sync, active-high); ex_* execute-stage operation; mm_ready accept handshake;
// mem_* request/response bus; wb_* writeback pulse; misalign flag.
// Build option MEM_MISALIGN_CHECK_EN: misaligned accesses are trapped instead of forced aligned.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_D,
    parameter int REG_W = REG_W_D
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_aluresult,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic [REG_W-1:0]  ex_dest_reg,
    input  logic              ex_mem_active,
    input  logic              ex_load,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    output logic              mm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_dest_reg,
    output logic [XLEN-1:0]   wb_result,
    output logic              misalign
);
    state_e            state_q, state_d;
    size_e             size_q, size_d;
    logic [XLEN-1:0]   addr_q, addr_d, data_q, data_d, wb_result_q, wb_result_d;
    logic [REG_W-1:0]  dest_q, dest_d, wb_dest_q, wb_dest_d;
    logic              load_q, load_d, uns_q, uns_d, wb_valid_q, wb_valid_d;
    logic [2:0]        off;
    logic [XLEN-1:0]   ld_result;
    logic              done;
    logic              store_req;

    // Low bits below the access size are dropped, so an access never straddles the doubleword.
    assign off       = addr_q[2:0] & ~size_mask(size_q);
    assign store_req = state_q == S_REQ && !load_q;
    assign done      = mem_rvalid && ((state_q == S_REQ && mem_gnt) || state_q == S_WAIT);

    assign mm_ready    = state_q == S_IDLE;
    assign mem_req     = state_q == S_REQ;
    assign mem_we      = store_req;
    assign mem_addr    = mem_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
    assign mem_wdata   = store_req ? data_q << {off, 3'b000} : '0;
    assign mem_wstrb   = store_req ? gen_strb(size_q, off) : '0;
    assign wb_valid    = wb_valid_q;
    assign wb_dest_reg = wb_dest_q;
    assign wb_result   = wb_result_q;

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i    (mem_rdata),
        .offset_i   (off),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (ld_result)
    );

`ifdef MEM_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic mis;
    assign mis      = |(ex_aluresult[2:0] & size_mask(size_e'(ex_size)));
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        dest_d      = dest_q;
        load_d      = load_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wb_valid_d  = 1'b0;
        wb_dest_d   = wb_dest_q;
        wb_result_d = wb_result_q;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (ex_valid) begin
                addr_d = ex_aluresult;
                data_d = ex_store_data;
                dest_d = ex_dest_reg;
                load_d = ex_load;
                size_d = size_e'(ex_size);
                uns_d  = ex_unsigned;
                if (!ex_mem_active) begin
                    wb_valid_d  = 1'b1;
                    wb_dest_d   = ex_dest_reg;
                    wb_result_d = ex_aluresult;
                end
`ifdef MEM_MISALIGN_CHECK_EN
                else if (mis) begin
                    wb_valid_d  = 1'b1;
                    wb_dest_d   = '0;
                    wb_result_d = '0;
                    misalign_d  = 1'b1;
                end
`endif
                else state_d = S_REQ;
            end
            S_REQ:  if (mem_gnt) state_d = mem_rvalid ? S_RESP : S_WAIT;
            S_WAIT: if (mem_rvalid) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
        endcase
        // The writeback registers are loaded on entry to RESP, so wb_valid is high exactly during RESP.
        if (done) begin
            wb_valid_d  = 1'b1;
            wb_dest_d   = load_q ? dest_q : '0;
            wb_result_d = (load_q && dest_q != '0) ? ld_result : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            dest_q      <= '0;
            load_q      <= 1'b0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_dest_q   <= '0;
            wb_result_q <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            dest_q      <= dest_d;
            load_q      <= load_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wb_valid_q  <= wb_valid_d;
            wb_dest_q   <= wb_dest_d;
            wb_result_q <= wb_result_d;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_q  <= misalign_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_mem_active, ex_load, ex_unsigned;
    logic [63:0] ex_aluresult, ex_store_data;
    logic [5:0]  ex_dest_reg;
    logic [1:0]  ex_size;
    logic        mm_ready, mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wstrb;
    logic        wb_valid, misalign;
    logic [5:0]  wb_dest_reg;
    logic [63:0] wb_result;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_aluresult(ex_aluresult),
        .ex_store_data(ex_store_data), .ex_dest_reg(ex_dest_reg), .ex_mem_active(ex_mem_active),
        .ex_load(ex_load), .ex_size(ex_size), .ex_unsigned(ex_unsigned), .mm_ready(mm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_dest_reg(wb_dest_reg), .wb_result(wb_result), .misalign(misalign)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Presents one operation for a single capture edge, then withdraws it.
    task automatic issue(input logic [63:0] a, input logic [63:0] d, input logic [5:0] rd,
                         input logic mem, input logic ld, input logic [1:0] sz, input logic un);
        ex_valid = 1'b1; ex_aluresult = a; ex_store_data = d; ex_dest_reg = rd;
        ex_mem_active = mem; ex_load = ld; ex_size = sz; ex_unsigned = un;
        tick();
        ex_valid = 1'b0;
    endtask

    // Grant immediately, return data one cycle later, then check the writeback pulse.
    task automatic load_op(input string tag, input logic [63:0] a, input logic [1:0] sz,
                           input logic un, input logic [5:0] rd, input logic [63:0] rdata,
                           input logic [63:0] exp_rd, input logic [63:0] exp);
        issue(a, 64'd0, rd, 1'b1, 1'b1, sz, un);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0;
        chk({tag, "_wbv"}, {63'd0, wb_valid}, 64'd1);
        chk({tag, "_rd"}, {58'd0, wb_dest_reg}, exp_rd);
        chk({tag, "_res"}, wb_result, exp);
        tick();
    endtask

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_aluresult = '0; ex_store_data = '0; ex_dest_reg = '0;
        ex_mem_active = 1'b0; ex_load = 1'b0; ex_size = 2'd0; ex_unsigned = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_ready", {63'd0, mm_ready}, 64'd1);
        chk("rst_req", {63'd0, mem_req}, 64'd0);
        chk("rst_wbv", {63'd0, wb_valid}, 64'd0);
        chk("rst_res", wb_result, 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_mis", {63'd0, misalign}, 64'd0);

        // ALU pass-through, then two back-to-back
        issue(64'h1234, 64'd0, 6'd5, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("alu_wbv", {63'd0, wb_valid}, 64'd1);
        chk("alu_rd", {58'd0, wb_dest_reg}, 64'd5);
        chk("alu_res", wb_result, 64'h1234);
        chk("alu_ready", {63'd0, mm_ready}, 64'd1);
        tick();
        chk("alu_pulse", {63'd0, wb_valid}, 64'd0);
        issue(64'hAAAA, 64'd0, 6'd1, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("b2b1_res", wb_result, 64'hAAAA);
        issue(64'h5555, 64'd0, 6'd2, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("b2b2_wbv", {63'd0, wb_valid}, 64'd1);
        chk("b2b2_res", wb_result, 64'h5555);
        tick();

        // Signed byte load with full REQ/WAIT/RESP walk
        issue(64'h1003, 64'd0, 6'd7, 1'b1, 1'b1, 2'd0, 1'b0);
        chk("lb_req", {63'd0, mem_req}, 64'd1);
        chk("lb_addr", mem_addr, 64'h1000);
        chk("lb_we", {63'd0, mem_we}, 64'd0);
        chk("lb_ready", {63'd0, mm_ready}, 64'd0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("lb_wait_req", {63'd0, mem_req}, 64'd0);
        chk("lb_wait_wbv", {63'd0, wb_valid}, 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 64'h00000000_80000000;
        tick();
        mem_rvalid = 1'b0;
        chk("lb_wbv", {63'd0, wb_valid}, 64'd1);
        chk("lb_rd", {58'd0, wb_dest_reg}, 64'd7);
        chk("lb_res", wb_result, 64'hFFFFFFFF_FFFFFF80);
        tick();
        chk("lb_pulse", {63'd0, wb_valid}, 64'd0);
        chk("lb_ready_back", {63'd0, mm_ready}, 64'd1);

        load_op("lbu", 64'h1003, 2'd0, 1'b1, 6'd7, 64'h00000000_80000000, 64'd7, 64'h80);
        load_op("lh", 64'h3002, 2'd1, 1'b0, 6'd8, 64'h00000000_F00D0000, 64'd8, 64'hFFFFFFFF_FFFFF00D);
        load_op("lw", 64'h3004, 2'd2, 1'b0, 6'd4, 64'h11223344_55667788, 64'd4, 64'h11223344);
        load_op("lw_r0", 64'h3004, 2'd2, 1'b0, 6'd0, 64'h11223344_55667788, 64'd0, 64'd0);

        // Store half with a 3-cycle grant stall
        issue(64'h1006, 64'hBEEF, 6'd3, 1'b1, 1'b0, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("sh_req", {63'd0, mem_req}, 64'd1);
            chk("sh_we", {63'd0, mem_we}, 64'd1);
            chk("sh_addr", mem_addr, 64'h1000);
            chk("sh_strb", {56'd0, mem_wstrb}, 64'hC0);
            chk("sh_wdata", mem_wdata, 64'hBEEF0000_00000000);
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("sh_wbv", {63'd0, wb_valid}, 64'd1);
        chk("sh_rd", {58'd0, wb_dest_reg}, 64'd0);
        chk("sh_res", wb_result, 64'd0);
        tick();

        // Double load with grant and response together
        issue(64'h2000, 64'd0, 6'd9, 1'b1, 1'b1, 2'd3, 1'b0);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h01234567_89ABCDEF;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("ld_same_wbv", {63'd0, wb_valid}, 64'd1);
        chk("ld_same_res", wb_result, 64'h01234567_89ABCDEF);
        chk("ld_same_busy", {63'd0, mm_ready}, 64'd0);
        tick();
        chk("ld_same_pulse", {63'd0, wb_valid}, 64'd0);
        chk("ld_same_ready", {63'd0, mm_ready}, 64'd1);

        // ex_valid while busy is ignored
        issue(64'h5000, 64'd0, 6'd10, 1'b1, 1'b1, 2'd3, 1'b0);
        issue(64'hDEAD, 64'd0, 6'd12, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("busy_wbv", {63'd0, wb_valid}, 64'd0);
        chk("busy_addr", mem_addr, 64'h5000);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h77;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("busy_rd", {58'd0, wb_dest_reg}, 64'd10);
        chk("busy_res", wb_result, 64'h77);
        tick();

        // Reset while waiting, then a late response
        issue(64'h4000, 64'd0, 6'd11, 1'b1, 1'b1, 2'd3, 1'b0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_req", {63'd0, mem_req}, 64'd0);
        chk("rw_ready", {63'd0, mm_ready}, 64'd1);
        chk("rw_wbv", {63'd0, wb_valid}, 64'd0);
        chk("rw_res", wb_result, 64'd0);
        chk("rw_rd", {58'd0, wb_dest_reg}, 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 64'h99;
        tick();
        mem_rvalid = 1'b0;
        chk("rw_late_wbv", {63'd0, wb_valid}, 64'd0);
        chk("rw_late_ready", {63'd0, mm_ready}, 64'd1);
        chk("rw_late_res", wb_result, 64'd0);

        // Misaligned word load
        issue(64'h1002, 64'd0, 6'd6, 1'b1, 1'b1, 2'd2, 1'b0);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("mis_flag", {63'd0, misalign}, 64'd1);
        chk("mis_wbv", {63'd0, wb_valid}, 64'd1);
        chk("mis_rd", {58'd0, wb_dest_reg}, 64'd0);
        chk("mis_req", {63'd0, mem_req}, 64'd0);
        tick();
        chk("mis_pulse", {63'd0, misalign}, 64'd0);
        chk("mis_ready", {63'd0, mm_ready}, 64'd1);
`else
        chk("mis_flag", {63'd0, misalign}, 64'd0);
        chk("mis_req", {63'd0, mem_req}, 64'd1);
        chk("mis_addr", mem_addr, 64'h1000);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hCAFEBABE_12345678;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("mis_res", wb_result, 64'h12345678);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
